// File: rtl/pwm_sample_decoder_if.sv
// Signal bundle between a PWM source and the sample decoder:
// the PWM line in one direction, recovered sample and status in the other.
interface pwm_sample_decoder_if #(
    parameter int SAMPLE_WIDTH = 8
);
    logic                    pwm_in;
    logic [SAMPLE_WIDTH-1:0] sample;
    logic                    sample_valid;
    logic                    frame_err;
    logic                    locked;

    modport master (
        output pwm_in,
        input  sample,
        input  sample_valid,
        input  frame_err,
        input  locked
    );

    modport slave (
        input  pwm_in,
        output sample,
        output sample_valid,
        output frame_err,
        output locked
    );
endinterface

// File: rtl/pwm_sample_decoder.sv
// Recovers one unsigned sample per PWM frame by counting high cycles between
// consecutive rising edges; also flags frames of wrong length and tracks lock.
module pwm_sample_decoder #(
    parameter int SAMPLE_WIDTH   = 8,
    parameter int TIMEOUT_FRAMES = 2
) (
    input  logic                  clock,
    input  logic                  resetn,
    pwm_sample_decoder_if.slave   bus
);
    localparam int PERIOD  = 1 << SAMPLE_WIDTH;
    localparam int TIMEOUT = TIMEOUT_FRAMES * PERIOD;
    localparam int CNT_W   = $clog2(TIMEOUT) + 1;

    localparam logic [CNT_W-1:0]        PERIOD_C   = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0]        TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [SAMPLE_WIDTH-1:0] SAMPLE_MAX = '1;

    typedef enum logic {SEEK, MEASURE} state_t;

    state_t                  state_q, state_d;
    logic                    meta_q, meta_d;
    logic                    sync_q, sync_d;
    logic                    sync_dly_q, sync_dly_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        high_cnt_q, high_cnt_d;
    logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;
    logic                    locked_q, locked_d;

    logic                    rise;
    logic                    timeout;
    logic [SAMPLE_WIDTH-1:0] level_sample;

    // High count can exceed the sample range on over-long frames; clamp it.
    function automatic logic [SAMPLE_WIDTH-1:0] sat_sample(input logic [CNT_W-1:0] h);
        if (h > CNT_W'(SAMPLE_MAX)) begin
            return SAMPLE_MAX;
        end
        return h[SAMPLE_WIDTH-1:0];
    endfunction

    assign rise         = sync_q & ~sync_dly_q;
    assign timeout      = (cnt_q == TIMEOUT_C);
    assign level_sample = sync_q ? SAMPLE_MAX : '0;

    always_comb begin
        meta_d     = bus.pwm_in;
        sync_d     = meta_q;
        sync_dly_d = sync_q;
    end

    // The cycle that ends a frame is the first cycle of the next one.
    always_comb begin
        if (rise || timeout) begin
            cnt_d      = CNT_W'(1);
            high_cnt_d = CNT_W'(sync_q);
        end else begin
            cnt_d      = cnt_q + CNT_W'(1);
            high_cnt_d = high_cnt_q + CNT_W'(sync_q);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SEEK:    if (rise)                 state_d = MEASURE;
            MEASURE: if (!rise && timeout)     state_d = SEEK;
            default:                           state_d = SEEK;
        endcase
    end

    // Rise wins over timeout when both land in the same cycle.
    always_comb begin
        sample_d = sample_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        locked_d = locked_q;
        case (state_q)
            SEEK: begin
                if (!rise && timeout) begin
                    sample_d = level_sample;
                    valid_d  = 1'b1;
                end
            end
            MEASURE: begin
                if (rise) begin
                    sample_d = sat_sample(high_cnt_q);
                    valid_d  = 1'b1;
                    if (cnt_q == PERIOD_C) begin
                        locked_d = 1'b1;
                    end else begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                    end
                end else if (timeout) begin
                    sample_d = level_sample;
                    valid_d  = 1'b1;
                    locked_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= SEEK;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            meta_q     <= 1'b0;
            sync_q     <= 1'b0;
            sync_dly_q <= 1'b0;
            cnt_q      <= '0;
            high_cnt_q <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            meta_q     <= meta_d;
            sync_q     <= sync_d;
            sync_dly_q <= sync_dly_d;
            cnt_q      <= cnt_d;
            high_cnt_q <= high_cnt_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            locked_q   <= locked_d;
        end
    end

    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.frame_err    = err_q;
    assign bus.locked       = locked_q;
endmodule

// File: tb/tb_pwm_sample_decoder.sv
// Directed bench for pwm_sample_decoder: drives whole PWM frames and checks
// the logged strobes against hand-computed samples, flags and spacing.
module tb_pwm_sample_decoder;
    localparam int SW = 8;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    pwm_sample_decoder_if #(.SAMPLE_WIDTH(SW)) bus ();

    pwm_sample_decoder #(.SAMPLE_WIDTH(SW), .TIMEOUT_FRAMES(2)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int s;
        int err;
        int lck;
        int cyc;
    } ev_t;

    ev_t ev_q[$];
    ev_t mon_e;

    always @(negedge clock) begin
        if (bus.sample_valid || bus.frame_err) begin
            mon_e.s   = int'(bus.sample);
            mon_e.err = int'(bus.frame_err);
            mon_e.lck = int'(bus.locked);
            mon_e.cyc = cyc;
            ev_q.push_back(mon_e);
        end
    end

    function automatic int ev_s(input int i);
        if (i < ev_q.size()) return ev_q[i].s;
        return -1;
    endfunction
    function automatic int ev_e(input int i);
        if (i < ev_q.size()) return ev_q[i].err;
        return -1;
    endfunction
    function automatic int ev_l(input int i);
        if (i < ev_q.size()) return ev_q[i].lck;
        return -1;
    endfunction
    function automatic int ev_c(input int i);
        if (i < ev_q.size()) return ev_q[i].cyc;
        return -1;
    endfunction

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic level, input int n);
        repeat (n) begin
            @(negedge clock);
            bus.pwm_in = level;
        end
    endtask

    task automatic frame(input int len, input int d, output int start);
        @(negedge clock);
        bus.pwm_in = 1'b1;
        start = cyc;
        drive(1'b1, d - 1);
        drive(1'b0, len - d);
    endtask

    task automatic clear_events();
        @(posedge clock);
        #1;
        ev_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int st2;
        int sweep_d[4];
        int exp_s[5];
        bus.pwm_in = 1'b0;
        resetn     = 1'b0;
        st2        = 0;
        repeat (3) @(negedge clock);
        check_val("rst_sample", int'(bus.sample), 0);
        check_val("rst_valid", int'(bus.sample_valid), 0);
        check_val("rst_err", int'(bus.frame_err), 0);
        check_val("rst_locked", int'(bus.locked), 0);
        resetn = 1'b1;

        // Nominal: 10 frames at D=100
        clear_events();
        for (int i = 0; i < 10; i++) begin
            frame(256, 100, st);
            if (i == 1) st2 = st;
        end
        check_val("nom_count", ev_q.size(), 9);
        check_val("nom_latency", ev_c(0) - st2, 3);
        for (int i = 0; i < 9; i++) begin
            check_val($sformatf("nom_sample%0d", i), ev_s(i), 100);
            check_val($sformatf("nom_err%0d", i), ev_e(i), 0);
            if (i > 0) begin
                check_val($sformatf("nom_locked%0d", i), ev_l(i), 1);
                check_val($sformatf("nom_spacing%0d", i), ev_c(i) - ev_c(i - 1), 256);
            end
        end

        // Sweep
        sweep_d = '{1, 127, 128, 255};
        exp_s   = '{100, 1, 127, 128, 255};
        clear_events();
        for (int i = 0; i < 4; i++) frame(256, sweep_d[i], st);
        frame(256, 100, st);
        check_val("sweep_count", ev_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("sweep_sample%0d", i), ev_s(i), exp_s[i]);
            check_val($sformatf("sweep_err%0d", i), ev_e(i), 0);
        end

        // Constant lines
        clear_events();
        drive(1'b0, 1200);
        drive(1'b1, 1200);
        drive(1'b0, 20);
        check_val("const_count", ev_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("const_sample%0d", i), ev_s(i), (i < 2) ? 0 : 255);
            check_val($sformatf("const_err%0d", i), ev_e(i), 0);
            check_val($sformatf("const_locked%0d", i), ev_l(i), 0);
        end
        check_val("const_spacing_lo", ev_c(1) - ev_c(0), 512);
        check_val("const_spacing_hi", ev_c(3) - ev_c(2), 512);

        // Length error
        clear_events();
        repeat (3) frame(256, 64, st);
        frame(300, 64, st);
        repeat (2) frame(256, 64, st);
        check_val("len_count", ev_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("len_sample%0d", i), ev_s(i), 64);
            check_val($sformatf("len_err%0d", i), ev_e(i), (i == 3) ? 1 : 0);
            check_val($sformatf("len_locked%0d", i), ev_l(i), (i == 3) ? 0 : 1);
        end

        // Saturation
        clear_events();
        frame(400, 380, st);
        frame(256, 64, st);
        check_val("sat_count", ev_q.size(), 2);
        check_val("sat_prev_sample", ev_s(0), 64);
        check_val("sat_sample", ev_s(1), 255);
        check_val("sat_err", ev_e(1), 1);
        check_val("sat_locked", ev_l(1), 0);

        // Reset mid-frame
        clear_events();
        drive(1'b1, 50);
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        check_val("mrst_sample", int'(bus.sample), 0);
        check_val("mrst_valid", int'(bus.sample_valid), 0);
        check_val("mrst_err", int'(bus.frame_err), 0);
        check_val("mrst_locked", int'(bus.locked), 0);
        resetn = 1'b1;
        drive(1'b1, 48);
        drive(1'b0, 156);
        check_val("mrst_count_pre", ev_q.size(), 1);
        check_val("mrst_prev_sample", ev_s(0), 64);
        frame(256, 100, st);
        frame(256, 100, st);
        check_val("mrst_count_post", ev_q.size(), 3);
        check_val("mrst_partial_err", ev_e(1), 1);
        check_val("mrst_sample", ev_s(2), 100);
        check_val("mrst_err_final", ev_e(2), 0);
        check_val("mrst_locked_final", ev_l(2), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
